// File: rtl/gpsdc_point_streamer.sv
// ============================================================================
// Module  : gpsdc_point_streamer
// Purpose : Buffers host coordinate points in a FIFO and streams them to the
//           GPS distance core (first point = A anchor, later points = B).
//           Collects core results and tags them with a pair index.
// Options : GPSDC_STREAM_WDT_EN - enables the S_HOLD watchdog (wdt_err).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpsdc_point_streamer #(
  parameter int DEPTH   = 8,
  parameter int IDX_W   = 16,
  parameter int WDT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [23:0]            wr_lon,
  input  logic [23:0]            wr_lat,
  input  logic                   restart,
  output logic                   full,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   overflow,
  output logic                   DEN,
  output logic [23:0]            LON_OUT,
  output logic [23:0]            LAT_OUT,
  input  logic                   core_valid,
  input  logic [39:0]            core_d,
  output logic                   res_valid,
  output logic [39:0]            res_d,
  output logic [IDX_W-1:0]       res_idx,
  output logic                   busy,
  output logic                   wdt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ANCHOR = 2'd1,
    S_WAITPT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [47:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop, empty;
  logic             den_nxt;
  logic             res_cap;
  logic             wdt_hit;
  logic [IDX_W-1:0] pair_cnt;

  // full/empty derive from the registered count only, so a push while full is
  // rejected even when a pop happens on the same edge
  assign full     = (count == CNT_MAX);
  assign empty    = (count == '0);
  assign push     = wr_en && !full;
  assign fifo_cnt = count;
  assign busy     = (state != S_IDLE);

  // point storage; contents are don't-care until pointers make them visible
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_lon, wr_lat};
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // next-state, pop and DEN decisions; restart overrides everything
  always_comb begin
    state_nxt = state;
    den_nxt   = DEN;
    pop       = 1'b0;
    res_cap   = 1'b0;
    if (restart) begin
      state_nxt = S_IDLE;
      den_nxt   = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          den_nxt = 1'b0;
          if (!empty) begin
            pop       = 1'b1;
            den_nxt   = 1'b1;
            state_nxt = S_ANCHOR;
          end
        end
        S_ANCHOR: begin
          if (!empty) begin
            pop       = 1'b1;
            den_nxt   = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            den_nxt   = 1'b0;
            state_nxt = S_WAITPT;
          end
        end
        S_WAITPT: begin
          den_nxt = 1'b0;
          if (!empty) begin
            pop       = 1'b1;
            den_nxt   = 1'b1;
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          den_nxt = 1'b1;
          if (core_valid) begin
            res_cap = 1'b1;
            if (!empty) begin
              pop = 1'b1;
            end else begin
              den_nxt   = 1'b0;
              state_nxt = S_WAITPT;
            end
          end else if (wdt_hit) begin
            den_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end
        end
        default: begin
          den_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // registered core-side outputs and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      DEN       <= 1'b0;
      LON_OUT   <= '0;
      LAT_OUT   <= '0;
      res_valid <= 1'b0;
      res_d     <= '0;
      res_idx   <= '0;
      pair_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      DEN       <= den_nxt;
      res_valid <= res_cap;
      if (pop) {LON_OUT, LAT_OUT} <= mem[rd_ptr];
      if (restart) begin
        res_idx  <= '0;
        pair_cnt <= '0;
      end else if (res_cap) begin
        res_d    <= core_d;
        res_idx  <= pair_cnt;
        pair_cnt <= pair_cnt + IDX_ONE;
      end
    end
  end

`ifdef GPSDC_STREAM_WDT_EN
  localparam int WW = $clog2(WDT_CYC + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYC - 1);
  localparam logic [WW-1:0] WDT_ONE  = WW'(1);

  logic [WW-1:0] wdt_cnt;

  // timeout fires on the edge where the HOLD cycle count would reach WDT_CYC
  assign wdt_hit = (state == S_HOLD) && !core_valid && (wdt_cnt == WDT_LAST);

  // HOLD cycle counter and sticky watchdog error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_cnt <= '0;
      wdt_err <= 1'b0;
    end else begin
      if (restart)      wdt_err <= 1'b0;
      else if (wdt_hit) wdt_err <= 1'b1;
      if ((state != S_HOLD) || core_valid || restart || wdt_hit) wdt_cnt <= '0;
      else                                                      wdt_cnt <= wdt_cnt + WDT_ONE;
    end
  end
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = (WDT_CYC == 0);
  assign wdt_hit = 1'b0;
  assign wdt_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpsdc_point_streamer.sv
// ============================================================================
// Module  : tb_gpsdc_point_streamer
// Purpose : Directed self-checking bench for gpsdc_point_streamer with point
//           and result scoreboards (default build, watchdog compiled out).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpsdc_point_streamer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [23:0] wr_lon, wr_lat;
  logic        restart;
  logic        full;
  logic [3:0]  fifo_cnt;
  logic        overflow;
  logic        DEN;
  logic [23:0] LON_OUT, LAT_OUT;
  logic        core_valid;
  logic [39:0] core_d;
  logic        res_valid;
  logic [39:0] res_d;
  logic [15:0] res_idx;
  logic        busy;
  logic        wdt_err;

  int vectors = 0;
  int miscompares = 0;

  logic [47:0] pt_q[$];
  logic [55:0] res_q[$];
  logic [15:0] idx_model;

  gpsdc_point_streamer #(.DEPTH(8), .IDX_W(16), .WDT_CYC(4096)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_lon(wr_lon), .wr_lat(wr_lat),
    .restart(restart), .full(full), .fifo_cnt(fifo_cnt), .overflow(overflow),
    .DEN(DEN), .LON_OUT(LON_OUT), .LAT_OUT(LAT_OUT), .core_valid(core_valid),
    .core_d(core_d), .res_valid(res_valid), .res_d(res_d), .res_idx(res_idx),
    .busy(busy), .wdt_err(wdt_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pt(input logic [23:0] lon, input logic [23:0] lat, input bit accepted);
    wr_en  = 1'b1;
    wr_lon = lon;
    wr_lat = lat;
    if (accepted) pt_q.push_back({lon, lat});
    tick();
    wr_en = 1'b0;
  endtask

  task automatic expect_issue(input string tag);
    logic [47:0] e;
    check({tag, "_den"}, 64'(DEN), 64'd1);
    if (pt_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed=%0h expected=<no point queued>", tag, {LON_OUT, LAT_OUT});
    end else begin
      e = pt_q.pop_front();
      check(tag, 64'({LON_OUT, LAT_OUT}), 64'(e));
    end
  endtask

  task automatic core_pulse(input logic [39:0] d, input bit expect_res);
    logic [55:0] e;
    core_valid = 1'b1;
    core_d     = d;
    if (expect_res) begin
      res_q.push_back({idx_model, d});
      idx_model++;
    end
    tick();
    core_valid = 1'b0;
    check("res_valid", 64'(res_valid), 64'(expect_res));
    if (expect_res) begin
      e = res_q.pop_front();
      check("res_idx_d", 64'({res_idx, res_d}), 64'(e));
    end
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_lon = '0; wr_lat = '0;
    restart = 1'b0; core_valid = 1'b0; core_d = '0; idx_model = '0;
    repeat (3) tick();

    // reset state
    check("rst_den", 64'(DEN), 0);
    check("rst_lonlat", 64'({LON_OUT, LAT_OUT}), 0);
    check("rst_res", 64'({res_valid, res_d, res_idx}), 0);
    check("rst_fifo", 64'({full, fifo_cnt, overflow}), 0);
    check("rst_busy_wdt", 64'({busy, wdt_err}), 0);
    reset_n = 1'b1;
    tick();

    // anchor then B, first result
    push_pt(24'h0C2A3F, 24'h190000, 1);
    check("cnt_after_p0", 64'(fifo_cnt), 1);
    check("den_idle", 64'(DEN), 0);
    push_pt(24'h0C2B00, 24'h190100, 1);
    expect_issue("anchor_p0");
    check("busy_anchor", 64'(busy), 1);
    push_pt(24'h0C2C00, 24'h190200, 1);
    expect_issue("b_p1");
    tick();
    check("hold_p1", 64'({DEN, LON_OUT, LAT_OUT}), 64'({1'b1, 24'h0C2B00, 24'h190100}));
    core_pulse(40'h0012345678, 1);
    expect_issue("b_p2");
    check("cnt_empty", 64'(fifo_cnt), 0);
    tick();
    check("strobe_1cyc", 64'(res_valid), 0);

    // FIFO runs dry -> WAITPT; late point gets issued
    core_pulse(40'h0087654321, 1);
    check("waitpt_den", 64'(DEN), 0);
    check("waitpt_busy", 64'(busy), 1);
    repeat (200) tick();
    core_pulse(40'hFFFFFFFFFF, 0);
    push_pt(24'h0D0000, 24'h1A0000, 1);
    check("no_same_cycle_pop", 64'(DEN), 0);
    tick();
    expect_issue("waitpt_p3");

    // fill to full, then overflow
    for (int i = 0; i < 8; i++) push_pt(24'h100000 + 24'(i), 24'h200000 + 24'(i), 1);
    check("full_cnt", 64'({full, fifo_cnt, overflow}), 64'({1'b1, 4'd8, 1'b0}));
    push_pt(24'hABCDEF, 24'h123456, 0);
    check("overflow_cnt", 64'({full, fifo_cnt, overflow}), 64'({1'b1, 4'd8, 1'b1}));
    for (int i = 0; i < 8; i++) begin
      core_pulse(40'h0100000000 + 40'(i), 1);
      expect_issue("drain");
      if (i == 0) check("full_clear", 64'(full), 0);
    end
    core_pulse(40'h0200000000, 1);
    check("ninth_not_issued", 64'({DEN, fifo_cnt}), 0);

    // restart coincident with core_valid
    push_pt(24'h0E0000, 24'h1B0000, 1);
    tick();
    expect_issue("hold_q0");
    push_pt(24'h0E0001, 24'h1B0001, 1);
    core_valid = 1'b1; restart = 1'b1; core_d = 40'h0300000000;
    tick();
    core_valid = 1'b0; restart = 1'b0; idx_model = '0;
    check("restart_nores", 64'(res_valid), 0);
    check("restart_state", 64'({DEN, busy, res_idx}), 0);
    check("restart_fifo_kept", 64'(fifo_cnt), 1);
    tick();
    expect_issue("restart_anchor");
    tick();
    check("anchor_1cyc", 64'(DEN), 0);
    push_pt(24'h0E0002, 24'h1B0002, 1);
    tick();
    expect_issue("restart_b");
    core_pulse(40'h0400000000, 1);

    // asynchronous reset in HOLD with buffered points
    push_pt(24'h0F0000, 24'h1C0000, 1);
    tick();
    expect_issue("hold_s0");
    for (int i = 1; i < 4; i++) push_pt(24'h0F0000 + 24'(i), 24'h1C0000, 1);
    check("buffered3", 64'(fifo_cnt), 3);
    reset_n = 1'b0;
    #1;
    check("async_rst_core", 64'({DEN, LON_OUT, LAT_OUT}), 0);
    check("async_rst_misc", 64'({fifo_cnt, full, overflow, busy, wdt_err, res_valid, res_d, res_idx}), 0);
    pt_q.delete();
    idx_model = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    push_pt(24'h112233, 24'h445566, 1);
    tick();
    expect_issue("post_rst_anchor");
    tick();
    check("post_rst_anchor_1cyc", 64'(DEN), 0);

    // long HOLD without core_valid: no watchdog in this build
    push_pt(24'h223344, 24'h556677, 1);
    tick();
    expect_issue("long_hold");
    repeat (100) tick();
    check("long_hold_den", 64'({DEN, busy, wdt_err}), 64'({1'b1, 1'b1, 1'b0}));
    check("scoreboard_empty", 64'(res_q.size() + pt_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
